// File: rtl/mem_pkg.sv
// mem_pkg
//   Shared definitions for the memory stage and the load/store unit:
//   LSU dtype codes, RV32I load/store funct3 codes, the response fault
//   encoding and the two GPIO register addresses that the LSU decodes.
package mem_pkg;

  // LSU dtype codes (dtypes_in). DT_NONE selects no byte banks.
  localparam logic [2:0] DT_BYTE               = 3'd0;
  localparam logic [2:0] DT_HALF_WORD          = 3'd1;
  localparam logic [2:0] DT_WORD               = 3'd2;
  localparam logic [2:0] DT_BYTE_UNSIGNED      = 3'd3;
  localparam logic [2:0] DT_HALF_WORD_UNSIGNED = 3'd4;
  localparam logic [2:0] DT_NONE               = 3'b111;

  // RV32I funct3 codes. Stores reuse the low three load encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_FUNCT3   = 2'd2
  } fault_e;

  // GPIO registers: plain word stores from this block's point of view.
  localparam logic [11:0] GPIO_A = 12'hEF0;
  localparam logic [11:0] GPIO_B = 12'hEF4;

endpackage

// File: rtl/mem_req_decode.sv
// mem_req_decode
//   Combinational decode of a load/store request.
//   Ports:
//     funct3   in  3  RV32I funct3
//     is_store in  1  1 = store, 0 = load
//     addr_lo  in  2  request byte address bits [1:0]
//     dtype    out 3  LSU dtype code (DT_NONE when the request faults)
//     fault    out 2  FAULT_NONE / FAULT_MISALIGN / FAULT_FUNCT3
module mem_req_decode
  import mem_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_store,
  input  logic [1:0] addr_lo,
  output logic [2:0] dtype,
  output logic [1:0] fault
);

  logic [2:0] dtype_raw;
  logic       legal;
  logic       misaligned;

  always_comb begin
    dtype_raw = DT_NONE;
    legal     = 1'b0;
    case (funct3)
      F3_LB:  begin dtype_raw = DT_BYTE;      legal = 1'b1; end
      F3_LH:  begin dtype_raw = DT_HALF_WORD; legal = 1'b1; end
      F3_LW:  begin dtype_raw = DT_WORD;      legal = 1'b1; end
      // Unsigned variants exist only for loads.
      F3_LBU: begin dtype_raw = DT_BYTE_UNSIGNED;      legal = !is_store; end
      F3_LHU: begin dtype_raw = DT_HALF_WORD_UNSIGNED; legal = !is_store; end
      default: ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (dtype_raw)
      DT_HALF_WORD, DT_HALF_WORD_UNSIGNED: misaligned = addr_lo[0];
      DT_WORD:                             misaligned = |addr_lo;
      default: ;
    endcase
  end

  // Illegal funct3 outranks misalignment.
  always_comb begin
    fault = FAULT_NONE;
    dtype = dtype_raw;
    if (!legal) begin
      fault = FAULT_FUNCT3;
      dtype = DT_NONE;
    end else if (misaligned) begin
      fault = FAULT_MISALIGN;
      dtype = DT_NONE;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Memory-stage front end between execute and the LSU. Accepts one
//   load/store per handshake, decodes funct3 into an LSU dtype, sequences
//   the LSU access across RD_LATENCY cycles and holds a registered response
//   (load data or fault) for writeback.
//   Ports:
//     clk, reset_n                 clock; synchronous active-low reset
//     req_valid/req_ready          request handshake (ready only in IDLE)
//     req_is_store, req_funct3,
//     req_addr, req_wdata, req_rd  request fields
//     lsu_addr, lsu_wdata,
//     lsu_we, lsu_dtype            LSU drive
//     lsu_rdata                    LSU read data, already extended
//     resp_valid/resp_ready        response handshake
//     resp_rdata, resp_rd,
//     resp_fault                   response fields
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DTYPE_WIDTH = 3,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_store,
  input  logic [2:0]             req_funct3,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  input  logic [4:0]             req_rd,
  output logic [ADDR_WIDTH-1:0]  lsu_addr,
  output logic [DATA_WIDTH-1:0]  lsu_wdata,
  output logic                   lsu_we,
  output logic [DTYPE_WIDTH-1:0] lsu_dtype,
  input  logic [DATA_WIDTH-1:0]  lsu_rdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_WIDTH-1:0]  resp_rdata,
  output logic [4:0]             resp_rd,
  output logic [1:0]             resp_fault
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;

  localparam logic [2:0] LAST_CNT = 3'(RD_LATENCY - 1);

  state_e                 state, state_next;
  logic [2:0]             cnt;
  logic                   is_store_q;
  logic [DTYPE_WIDTH-1:0] dtype_q;
  logic [2:0]             dec_dtype;
  logic [1:0]             dec_fault;
  logic                   accept;
  logic                   dec_ok;
  logic                   last_beat;

  mem_req_decode u_decode (
    .funct3   (req_funct3),
    .is_store (req_is_store),
    .addr_lo  (req_addr[1:0]),
    .dtype    (dec_dtype),
    .fault    (dec_fault)
  );

  assign accept = req_valid && req_ready;
  assign dec_ok = (dec_fault == FAULT_NONE);

  // Final cycle of a load access: lsu_rdata is valid at the closing edge.
  assign last_beat = (state == S_ACCESS && !is_store_q && RD_LATENCY == 1) ||
                     (state == S_WAIT && cnt == LAST_CNT);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = dec_ok ? S_ACCESS : S_RESP;
      S_ACCESS: state_next = (is_store_q || RD_LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:   if (cnt == LAST_CNT) state_next = S_RESP;
      S_RESP:   if (resp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // WAIT counter: 1 on entry, terminal at RD_LATENCY-1.
  always_ff @(posedge clk) begin
    if (!reset_n)              cnt <= 3'd0;
    else if (state == S_ACCESS) cnt <= 3'd1;
    else if (state == S_WAIT)   cnt <= cnt + 3'd1;
  end

  // Latched request kind and dtype; only meaningful during ACCESS/WAIT.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_store_q <= req_is_store;
      dtype_q    <= DTYPE_WIDTH'(dec_dtype);
    end
  end

  // LSU address/data and response registers. The LSU address/data only
  // move for requests that will really access the LSU, so they otherwise
  // hold their last values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lsu_addr   <= '0;
      lsu_wdata  <= '0;
      resp_rdata <= '0;
      resp_rd    <= '0;
      resp_fault <= '0;
    end else if (accept) begin
      if (dec_ok) begin
        lsu_addr  <= req_addr;
        lsu_wdata <= req_wdata;
      end
      resp_rdata <= '0;
      resp_rd    <= (!req_is_store && dec_ok) ? req_rd : 5'd0;
      resp_fault <= dec_fault;
    end else if (last_beat) begin
      resp_rdata <= lsu_rdata;
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign lsu_we     = (state == S_ACCESS) && is_store_q;
  assign lsu_dtype  = (state == S_ACCESS || state == S_WAIT) ? dtype_q
                                                             : DTYPE_WIDTH'(DT_NONE);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
//   Drives two instances (RD_LATENCY 1 and 3) with directed and random
//   load/store requests. Each instance has its own LSU stand-in (byte memory
//   with read latency) and a byte-level shadow memory used to predict
//   responses, fault codes, access length and response latency.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n      [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_is_store [2];
  logic [2:0]  req_funct3   [2];
  logic [11:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic [4:0]  req_rd       [2];
  logic [11:0] lsu_addr     [2];
  logic [31:0] lsu_wdata    [2];
  logic        lsu_we       [2];
  logic [2:0]  lsu_dtype    [2];
  logic [31:0] lsu_rdata    [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [31:0] resp_rdata   [2];
  logic [4:0]  resp_rd      [2];
  logic [1:0]  resp_fault   [2];

  mem_stage_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DTYPE_WIDTH(3), .RD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_is_store(req_is_store[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_rd(req_rd[0]), .lsu_addr(lsu_addr[0]),
    .lsu_wdata(lsu_wdata[0]), .lsu_we(lsu_we[0]), .lsu_dtype(lsu_dtype[0]),
    .lsu_rdata(lsu_rdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_rd(resp_rd[0]), .resp_fault(resp_fault[0])
  );

  mem_stage_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DTYPE_WIDTH(3), .RD_LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_is_store(req_is_store[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_rd(req_rd[1]), .lsu_addr(lsu_addr[1]),
    .lsu_wdata(lsu_wdata[1]), .lsu_we(lsu_we[1]), .lsu_dtype(lsu_dtype[1]),
    .lsu_rdata(lsu_rdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_rd(resp_rd[1]), .resp_fault(resp_fault[1])
  );

  function automatic int lat(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  // ---------------- LSU stand-in ----------------
  bit [7:0]    mem          [2][4096];
  int          we_total     [2];
  int          acc_cycles   [2];
  int          addr_changes [2];
  int          stable       [2];
  logic [2:0]  dt_last      [2];
  logic        prev_acc     [2];
  logic [11:0] prev_addr    [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (lsu_we[k] === 1'b1) begin
        we_total[k] <= we_total[k] + 1;
        case (lsu_dtype[k])
          3'd0: mem[k][lsu_addr[k]] <= lsu_wdata[k][7:0];
          3'd1: begin
            mem[k][lsu_addr[k]]         <= lsu_wdata[k][7:0];
            mem[k][lsu_addr[k] + 12'd1] <= lsu_wdata[k][15:8];
          end
          3'd2: begin
            mem[k][lsu_addr[k]]         <= lsu_wdata[k][7:0];
            mem[k][lsu_addr[k] + 12'd1] <= lsu_wdata[k][15:8];
            mem[k][lsu_addr[k] + 12'd2] <= lsu_wdata[k][23:16];
            mem[k][lsu_addr[k] + 12'd3] <= lsu_wdata[k][31:24];
          end
          default: ;
        endcase
      end
      if (lsu_dtype[k] !== 3'b111) begin
        acc_cycles[k] <= acc_cycles[k] + 1;
        dt_last[k]    <= lsu_dtype[k];
        if (prev_acc[k] && lsu_addr[k] !== prev_addr[k])
          addr_changes[k] <= addr_changes[k] + 1;
        stable[k]   <= stable[k] + 1;
        prev_acc[k] <= 1'b1;
      end else begin
        stable[k]   <= 0;
        prev_acc[k] <= 1'b0;
      end
      prev_addr[k] <= lsu_addr[k];
    end
  end

  // Read data is only valid once address/dtype have been stable long enough.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      lsu_rdata[k] = 32'hBAD0_BAD0;
      if (lsu_dtype[k] != 3'b111 && stable[k] >= lat(k) - 1) begin
        case (lsu_dtype[k])
          3'd0: lsu_rdata[k] = {{24{mem[k][lsu_addr[k]][7]}}, mem[k][lsu_addr[k]]};
          3'd1: lsu_rdata[k] = {{16{mem[k][lsu_addr[k] + 12'd1][7]}},
                                mem[k][lsu_addr[k] + 12'd1], mem[k][lsu_addr[k]]};
          3'd2: lsu_rdata[k] = {mem[k][lsu_addr[k] + 12'd3], mem[k][lsu_addr[k] + 12'd2],
                                mem[k][lsu_addr[k] + 12'd1], mem[k][lsu_addr[k]]};
          3'd3: lsu_rdata[k] = {24'd0, mem[k][lsu_addr[k]]};
          3'd4: lsu_rdata[k] = {16'd0, mem[k][lsu_addr[k] + 12'd1], mem[k][lsu_addr[k]]};
          default: ;
        endcase
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit [7:0] shadow [2][4096];

  task automatic txn(input int k, input bit st, input logic [2:0] f3, input logic [11:0] a,
                     input logic [31:0] wd, input logic [4:0] rd, input int hold);
    int size, exp_fault, exp_lat, exp_acc, cyc, we0, acc0, ch0;
    bit sgn, legal, busy_ok;
    logic [2:0] exp_dt;
    logic [31:0] val, exp_data;
    logic [4:0] exp_rd;
    logic [40:0] snap;

    size = 1; sgn = 1'b1; legal = 1'b1; exp_dt = 3'b111;
    case (f3)
      3'b000: begin size = 1; exp_dt = 3'd0; end
      3'b001: begin size = 2; exp_dt = 3'd1; end
      3'b010: begin size = 4; exp_dt = 3'd2; end
      3'b100: begin size = 1; sgn = 1'b0; exp_dt = 3'd3; legal = !st; end
      3'b101: begin size = 2; sgn = 1'b0; exp_dt = 3'd4; legal = !st; end
      default: legal = 1'b0;
    endcase
    if (!legal)                exp_fault = 2;
    else if (int'(a) % size != 0) exp_fault = 1;
    else                       exp_fault = 0;
    if (exp_fault != 0) exp_dt = 3'b111;

    exp_data = 32'd0;
    if (exp_fault == 0 && st) begin
      for (int i = 0; i < size; i++) shadow[k][a + 12'(i)] = wd[8*i +: 8];
    end else if (exp_fault == 0) begin
      val = 32'd0;
      for (int i = 0; i < size; i++) val[8*i +: 8] = shadow[k][a + 12'(i)];
      if (sgn && val[8*size-1]) for (int i = 8*size; i < 32; i++) val[i] = 1'b1;
      exp_data = val;
    end
    exp_rd  = (!st && exp_fault == 0) ? rd : 5'd0;
    exp_lat = (exp_fault != 0) ? 1 : (st ? 2 : 1 + lat(k));
    exp_acc = (exp_fault != 0) ? 0 : (st ? 1 : lat(k));

    @(negedge clk);
    chk("req_ready_idle", req_ready[k], 1);
    req_is_store[k] = st; req_funct3[k] = f3; req_addr[k] = a;
    req_wdata[k] = wd; req_rd[k] = rd;
    req_valid[k] = 1'b1;
    resp_ready[k] = (hold == 0);
    we0 = we_total[k]; acc0 = acc_cycles[k]; ch0 = addr_changes[k];
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_addr[k] = 12'($urandom); req_wdata[k] = $urandom; req_rd[k] = 5'($urandom);
    req_funct3[k] = 3'($urandom); req_is_store[k] = 1'($urandom);

    cyc = 0; busy_ok = 1'b1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (resp_valid[k]) break;
      if (req_ready[k]) busy_ok = 1'b0;
    end
    chk("latency", cyc, exp_lat);
    chk("busy_not_ready", busy_ok, 1);
    chk("resp_rdata", resp_rdata[k], exp_data);
    chk("resp_rd", resp_rd[k], exp_rd);
    chk("resp_fault", resp_fault[k], exp_fault);
    chk("we_pulses", we_total[k] - we0, (st && exp_fault == 0) ? 1 : 0);
    chk("access_cycles", acc_cycles[k] - acc0, exp_acc);
    chk("addr_stable", addr_changes[k] - ch0, 0);
    if (exp_fault == 0) begin
      chk("dtype", dt_last[k], exp_dt);
      chk("lsu_addr", lsu_addr[k], a);
      if (st) chk("lsu_wdata", lsu_wdata[k], wd);
    end else begin
      chk("dtype_idle", lsu_dtype[k], 3'b111);
    end

    if (hold > 0) begin
      snap = {resp_valid[k], req_ready[k], resp_rdata[k], resp_rd[k], resp_fault[k]};
      we0 = we_total[k]; acc0 = acc_cycles[k];
      req_valid[k] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_stable", {resp_valid[k], req_ready[k], resp_rdata[k], resp_rd[k], resp_fault[k]},
            {1'b1, 1'b0, exp_data, exp_rd, 2'(exp_fault)});
      end
      chk("hold_no_access", (we_total[k] - we0) + (acc_cycles[k] - acc0), 0);
      req_valid[k] = 1'b0;
      resp_ready[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("back_to_idle", {resp_valid[k], req_ready[k]}, 2'b01);
    resp_ready[k] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc_seen;
    for (int k = 0; k < 2; k++) begin
      reset_n[k] = 1'b0; req_valid[k] = 1'b0; resp_ready[k] = 1'b0;
      req_is_store[k] = 1'b0; req_funct3[k] = 3'd0; req_addr[k] = 12'd0;
      req_wdata[k] = 32'd0; req_rd[k] = 5'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", req_ready[k], 1);
      chk("reset_resp", {resp_valid[k], resp_rdata[k], resp_rd[k], resp_fault[k]}, 0);
      chk("reset_lsu", {lsu_we[k], lsu_addr[k], lsu_wdata[k]}, 0);
      chk("reset_dtype", lsu_dtype[k], 3'b111);
      reset_n[k] = 1'b1;
    end

    for (int k = 0; k < 2; k++) begin
      // store/load word round trip
      txn(k, 1, 3'b010, 12'h010, 32'hDEAD_BEEF, 5'd3, 0);
      txn(k, 0, 3'b010, 12'h010, 32'h0, 5'd5, 0);
      // byte store, signed and unsigned byte load
      txn(k, 1, 3'b000, 12'h013, 32'h0000_0081, 5'd0, 0);
      txn(k, 0, 3'b000, 12'h013, 32'h0, 5'd7, 0);
      txn(k, 0, 3'b100, 12'h013, 32'h0, 5'd8, 0);
      // faults
      txn(k, 0, 3'b001, 12'h011, 32'h0, 5'd9, 0);
      txn(k, 0, 3'b010, 12'h012, 32'h0, 5'd10, 0);
      txn(k, 1, 3'b100, 12'h020, 32'h1234_5678, 5'd11, 0);
      txn(k, 0, 3'b011, 12'h020, 32'h0, 5'd12, 0);
      // GPIO words
      txn(k, 1, 3'b010, 12'hEF0, 32'hA5A5_0001, 5'd0, 0);
      txn(k, 1, 3'b010, 12'hEF4, 32'h5A5A_0002, 5'd0, 0);
      txn(k, 0, 3'b010, 12'hEF4, 32'h0, 5'd13, 0);
      // backpressure with a pending new request
      txn(k, 0, 3'b010, 12'h010, 32'h0, 5'd14, 5);
      txn(k, 0, 3'b101, 12'h012, 32'h0, 5'd15, 2);
    end

    // reset during WAIT on the latency-3 instance
    @(negedge clk);
    req_is_store[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 12'h010;
    req_rd[1] = 5'd20; req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_wait_dtype", lsu_dtype[1], 3'd2);
    reset_n[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_abort", {resp_valid[1], req_ready[1], lsu_we[1], lsu_dtype[1]}, {1'b0, 1'b1, 1'b0, 3'b111});
    @(negedge clk);
    reset_n[1] = 1'b1;
    resp_ready[1] = 1'b1;
    cyc_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid[1]) cyc_seen++;
    end
    chk("no_stale_resp", cyc_seen, 0);
    resp_ready[1] = 1'b0;
    txn(1, 0, 3'b010, 12'h010, 32'h0, 5'd21, 0);

    // randomized traffic
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 80; n++) begin
        logic [11:0] a;
        int hold;
        a = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 12'hEF0 : 12'hEF4)
                                        : 12'($urandom_range(0, 63));
        hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0;
        txn(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            5'($urandom_range(1, 31)), hold);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
